// File: rtl/dl_run_ctrl.sv
// DL166 run/debug controller: gates the core clock enable and arbitrates program memory with the loader.
// Define DL_WATCHDOG_EN to bound every RUN to RUN_LIMIT executed instructions.
module dl_run_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int RUN_LIMIT = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halted,
  output logic              bp_hit,
  output logic              cmd_err,
  output logic [CNT_W-1:0]  retired,
  output logic              wd_hit
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_LOAD} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;
  localparam logic [2:0] OP_SETBP  = 3'd5;
  localparam logic [2:0] OP_CLRBP  = 3'd6;
  localparam logic [2:0] OP_CLRCNT = 3'd7;

  state_t            state, state_nx;
  logic              cpu_en_nx, mem_sel_nx, mem_we_nx;
  logic              bp_hit_nx, cmd_err_nx, wd_hit_nx;
  logic [ADDR_W-1:0] mem_addr_nx, bp_addr, bp_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic              bp_en, bp_en_nx, arm_skip, arm_skip_nx;
  logic              clr_cnt, accept, bp_match, wd_fire;

  assign cmd_ready = (state == S_HALT) || (state == S_RUN);
  assign accept    = cmd_valid && cmd_ready;
  // arm_skip lets a resumed RUN execute the instruction sitting on the breakpoint.
  assign bp_match  = bp_en && (pc == bp_addr) && !arm_skip;

`ifdef DL_WATCHDOG_EN
  localparam int RC_W = $clog2(RUN_LIMIT + 1);
  logic [RC_W-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      run_cnt <= '0;
    else if (state == S_RUN && cpu_en)
      run_cnt <= run_cnt + RC_W'(1);
    else
      run_cnt <= '0;
  end

  assign wd_fire = (state == S_RUN) && (run_cnt == RC_W'(RUN_LIMIT - 1));
`else
  // Without the watchdog RUN is unbounded; RUN_LIMIT only keeps the parameter list stable.
  assign wd_fire = (RUN_LIMIT < 0);
`endif

  always_comb begin
    state_nx     = state;
    cpu_en_nx    = 1'b0;
    mem_sel_nx   = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    bp_hit_nx    = 1'b0;
    cmd_err_nx   = 1'b0;
    wd_hit_nx    = 1'b0;
    bp_en_nx     = bp_en;
    bp_addr_nx   = bp_addr;
    arm_skip_nx  = arm_skip;
    clr_cnt      = 1'b0;
    case (state)
      S_HALT: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_nx    = S_RUN;
              cpu_en_nx   = 1'b1;
              arm_skip_nx = 1'b1;
            end
            OP_STEP: begin
              state_nx  = S_STEP;
              cpu_en_nx = 1'b1;
            end
            OP_WRITE: begin
              state_nx     = S_LOAD;
              mem_sel_nx   = 1'b1;
              mem_we_nx    = 1'b1;
              mem_addr_nx  = cmd_addr;
              mem_wdata_nx = cmd_data;
            end
            OP_SETBP: begin
              bp_addr_nx = cmd_addr;
              bp_en_nx   = 1'b1;
            end
            OP_CLRBP:        bp_en_nx = 1'b0;
            OP_CLRCNT:       clr_cnt  = 1'b1;
            OP_NOP, OP_HALT: ;
            default:         ;
          endcase
        end
      end
      S_RUN: begin
        arm_skip_nx = 1'b0;
        cpu_en_nx   = 1'b1;
        if (accept) begin
          case (cmd_op)
            OP_HALT: begin
              state_nx  = S_HALT;
              cpu_en_nx = 1'b0;
            end
            OP_WRITE, OP_STEP, OP_SETBP, OP_CLRBP: cmd_err_nx = 1'b1;
            OP_CLRCNT:      clr_cnt = 1'b1;
            OP_NOP, OP_RUN: ;
            default:        ;
          endcase
        end
        // Breakpoint and watchdog override everything and may pulse together.
        if (bp_match) begin
          state_nx  = S_HALT;
          cpu_en_nx = 1'b0;
          bp_hit_nx = 1'b1;
        end
        if (wd_fire) begin
          state_nx  = S_HALT;
          cpu_en_nx = 1'b0;
          wd_hit_nx = 1'b1;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_HALT;
      halted    <= 1'b1;
      cpu_en    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bp_hit    <= 1'b0;
      cmd_err   <= 1'b0;
      wd_hit    <= 1'b0;
      bp_en     <= 1'b0;
      bp_addr   <= '0;
      arm_skip  <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_nx;
      halted    <= (state_nx == S_HALT);
      cpu_en    <= cpu_en_nx;
      mem_sel   <= mem_sel_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      bp_hit    <= bp_hit_nx;
      cmd_err   <= cmd_err_nx;
      wd_hit    <= wd_hit_nx;
      bp_en     <= bp_en_nx;
      bp_addr   <= bp_addr_nx;
      arm_skip  <= arm_skip_nx;
      if (clr_cnt)
        retired <= '0;
      else if (cpu_en && retired != '1)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dl_run_ctrl.sv
// Self-checking bench for dl_run_ctrl: directed debug scenarios plus randomized commands
// compared every cycle against a behavioural model of the controller.
module tb_dl_run_ctrl;
  localparam int LIMIT = 10;
  localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3,
                         OP_WRITE = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6, OP_CLRCNT = 3'd7;
  localparam int MD_HALT = 0, MD_RUN = 1, MD_STEP = 2, MD_LOAD = 3;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_addr, pc, mem_addr;
  logic [7:0] cmd_data, mem_wdata, retired;
  logic       cpu_en, mem_sel, mem_we, halted, bp_hit, cmd_err, wd_hit;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit m_valid = 0;
  int m_mode, m_ret, m_addr, m_wdata, m_bp_at, m_runlen;
  bit m_cpu, m_sel, m_we, m_bphit, m_err, m_wd, m_bp_on, m_first;

  dl_run_ctrl #(.ADDR_W(4), .DATA_W(8), .CNT_W(8), .RUN_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .pc(pc),
    .cpu_en(cpu_en), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .halted(halted), .bp_hit(bp_hit), .cmd_err(cmd_err),
    .retired(retired), .wd_hit(wd_hit)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle; returns in the cycle after it was sampled.
  task automatic apply_stimulus(input logic [2:0] op, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  // Model: applies the controller's rules to whatever was presented at this edge.
  always @(posedge clk) begin
    bit acc, stop_cmd, bp, wd;
    int op;
    if (!reset) begin
      m_mode = MD_HALT; m_cpu = 0; m_sel = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_bphit = 0; m_err = 0; m_wd = 0; m_ret = 0; m_bp_on = 0; m_bp_at = 0;
      m_first = 0; m_runlen = 0; m_valid = 1;
    end else if (m_valid) begin
      acc = cmd_valid && (m_mode == MD_HALT || m_mode == MD_RUN);
      op  = acc ? int'(cmd_op) : -1;
      if (op == 7) m_ret = 0;
      else if (m_cpu && m_ret < 255) m_ret = m_ret + 1;
      m_bphit = 0; m_err = 0; m_wd = 0; m_we = 0; m_sel = 0;
      if (m_mode == MD_STEP || m_mode == MD_LOAD) begin
        m_mode = MD_HALT;
        m_cpu  = 0;
      end else if (m_mode == MD_HALT) begin
        m_cpu = 0;
        case (op)
          1: begin m_mode = MD_RUN; m_cpu = 1; m_first = 1; m_runlen = 0; end
          3: begin m_mode = MD_STEP; m_cpu = 1; end
          4: begin m_mode = MD_LOAD; m_sel = 1; m_we = 1; m_addr = int'(cmd_addr); m_wdata = int'(cmd_data); end
          5: begin m_bp_on = 1; m_bp_at = int'(cmd_addr); end
          6: m_bp_on = 0;
          default: ;
        endcase
      end else begin
        m_runlen = m_runlen + 1;
        bp       = m_bp_on && (int'(pc) == m_bp_at) && !m_first;
        m_first  = 0;
        stop_cmd = (op == 2);
        m_err    = (op == 3 || op == 4 || op == 5 || op == 6);
`ifdef DL_WATCHDOG_EN
        wd = (m_runlen >= LIMIT);
`else
        wd = 0;
`endif
        m_bphit = bp;
        m_wd    = wd;
        if (stop_cmd || bp || wd) begin
          m_mode = MD_HALT;
          m_cpu  = 0;
        end else begin
          m_cpu = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("cmd_ready", 32'(cmd_ready), 32'(m_mode == MD_HALT || m_mode == MD_RUN));
      check_output("halted", 32'(halted), 32'(m_mode == MD_HALT));
      check_output("cpu_en", 32'(cpu_en), 32'(m_cpu));
      check_output("mem_sel", 32'(mem_sel), 32'(m_sel));
      check_output("mem_we", 32'(mem_we), 32'(m_we));
      check_output("mem_addr", 32'(mem_addr), 32'(m_addr));
      check_output("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check_output("bp_hit", 32'(bp_hit), 32'(m_bphit));
      check_output("cmd_err", 32'(cmd_err), 32'(m_err));
      check_output("wd_hit", 32'(wd_hit), 32'(m_wd));
      check_output("retired", 32'(retired), 32'(m_ret));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n_cpu, n_bp, n_wd, r;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = '0; cmd_data = '0; pc = '0;
    repeat (2) tick();
    reset = 1'b1;
    check_output("rst_halted", 32'(halted), 32'd1);
    check_output("rst_cpu_en", 32'(cpu_en), 32'd0);
    check_output("rst_retired", 32'(retired), 32'd0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] single step x3");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(OP_STEP, 4'd0, 8'd0);
      check_output("step_cpu_en", 32'(cpu_en), 32'd1);
      check_output("step_halted", 32'(halted), 32'd0);
      tick();
      check_output("step_done_cpu_en", 32'(cpu_en), 32'd0);
      check_output("step_done_halted", 32'(halted), 32'd1);
    end
    check_output("step_retired", 32'(retired), 32'd3);

    $display("[TB] program write");
    apply_stimulus(OP_WRITE, 4'd5, 8'h96);
    check_output("wr_sel", 32'(mem_sel), 32'd1);
    check_output("wr_we", 32'(mem_we), 32'd1);
    check_output("wr_addr", 32'(mem_addr), 32'd5);
    check_output("wr_data", 32'(mem_wdata), 32'h96);
    check_output("wr_cpu_en", 32'(cpu_en), 32'd0);
    tick();
    check_output("wr_done_we", 32'(mem_we), 32'd0);

    $display("[TB] breakpoint at 4");
    apply_stimulus(OP_SETBP, 4'd4, 8'd0);
    pc = 4'd0;
    apply_stimulus(OP_RUN, 4'd0, 8'd0);
    n_cpu = 0; n_bp = 0;
    for (int k = 1; k <= 8; k++) begin
      n_cpu += int'(cpu_en);
      n_bp  += int'(bp_hit);
      pc = (k < 4) ? 4'(k) : 4'd4;
      tick();
    end
    check_output("bp_cpu_cycles", 32'(n_cpu), 32'd4);
    check_output("bp_hits", 32'(n_bp), 32'd1);
    check_output("bp_halted", 32'(halted), 32'd1);
    apply_stimulus(OP_RUN, 4'd0, 8'd0);
    n_cpu = 0; n_bp = 0;
    for (int k = 1; k <= 5; k++) begin
      n_cpu += int'(cpu_en);
      n_bp  += int'(bp_hit);
      pc = 4'(4 + k);
      tick();
    end
    check_output("resume_cpu_cycles", 32'(n_cpu), 32'd5);
    check_output("resume_no_rehit", 32'(n_bp), 32'd0);
    apply_stimulus(OP_HALT, 4'd0, 8'd0);
    check_output("halt_cpu_en", 32'(cpu_en), 32'd0);

    $display("[TB] illegal write while running");
    pc = 4'd9;
    apply_stimulus(OP_RUN, 4'd0, 8'd0);
    apply_stimulus(OP_WRITE, 4'd3, 8'h11);
    check_output("run_wr_err", 32'(cmd_err), 32'd1);
    check_output("run_wr_we", 32'(mem_we), 32'd0);
    check_output("run_wr_cpu_en", 32'(cpu_en), 32'd1);
    apply_stimulus(OP_HALT, 4'd0, 8'd0);
    check_output("run_halt_cpu_en", 32'(cpu_en), 32'd0);

    $display("[TB] reset during load and run");
    apply_stimulus(OP_WRITE, 4'd2, 8'h5A);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_output("rload_we", 32'(mem_we), 32'd0);
    check_output("rload_halted", 32'(halted), 32'd1);
    check_output("rload_retired", 32'(retired), 32'd0);
    apply_stimulus(OP_SETBP, 4'd7, 8'd0);
    pc = 4'd1;
    apply_stimulus(OP_RUN, 4'd0, 8'd0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_output("rrun_cpu_en", 32'(cpu_en), 32'd0);
    check_output("rrun_halted", 32'(halted), 32'd1);
    check_output("rrun_retired", 32'(retired), 32'd0);
    pc = 4'd7;
    apply_stimulus(OP_RUN, 4'd0, 8'd0);
    n_bp = 0;
    for (int k = 0; k < 4; k++) begin
      n_bp += int'(bp_hit);
      tick();
    end
    check_output("rrun_bp_cleared", 32'(n_bp), 32'd0);
    apply_stimulus(OP_HALT, 4'd0, 8'd0);

    $display("[TB] retired saturation");
    pc = 4'd0;
    apply_stimulus(OP_CLRBP, 4'd0, 8'd0);
    for (int k = 0; k < 2000 && m_ret < 255; k++) begin
      if (m_mode == MD_HALT) apply_stimulus(OP_RUN, 4'd0, 8'd0);
      else tick();
    end
    repeat (3) tick();
    check_output("sat_retired", 32'(retired), 32'hFF);
    apply_stimulus(OP_CLRCNT, 4'd0, 8'd0);
    check_output("clrcnt_retired", 32'(retired), 32'd0);
    if (m_mode == MD_RUN) apply_stimulus(OP_HALT, 4'd0, 8'd0);

`ifdef DL_WATCHDOG_EN
    $display("[TB] watchdog");
    tick();
    apply_stimulus(OP_RUN, 4'd0, 8'd0);
    n_cpu = 0; n_wd = 0;
    for (int k = 0; k < 15; k++) begin
      n_cpu += int'(cpu_en);
      n_wd  += int'(wd_hit);
      tick();
    end
    check_output("wd_cpu_cycles", 32'(n_cpu), 32'(LIMIT));
    check_output("wd_pulses", 32'(n_wd), 32'd1);
    check_output("wd_halted", 32'(halted), 32'd1);
`else
    n_wd = 0;
`endif

    $display("[TB] random commands");
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 299) != 0);
      pc        = 4'($urandom_range(0, 15));
      cmd_valid = ($urandom_range(0, 1) == 1);
      r         = $urandom_range(0, 10);
      cmd_op    = (r > 7) ? OP_RUN : 3'(r);
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_data  = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dl_run_ctrl.md
Name: dl_run_ctrl

Overview:
Run/debug controller for the 4-bit DL166 core. It gates the core's per-instruction clock enable (run, halt, single-step, PC breakpoint) and arbitrates the 16-entry program memory between core fetch and a command-driven loader port. It sits between the board command interface (UART/button decoder) and the core's clock-enable input and the program-memory write port.

Parameters:
ADDR_W, 4, program address / PC width (memory depth 2**ADDR_W)
DATA_W, 8, instruction width
CNT_W, 8, retired-instruction counter width
RUN_LIMIT, 200, watchdog cycle limit (used only with DL_WATCHDOG_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 WRITE, 5 SETBP, 6 CLRBP, 7 CLRCNT
cmd_addr  in  ADDR_W  WRITE address / breakpoint address
cmd_data  in  DATA_W  WRITE data
pc  in  ADDR_W  current core PC
cpu_en  out  1  core executes one instruction in cycles where high
mem_sel  out  1  1 = loader owns program memory
mem_we  out  1  program memory write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
halted  out  1  state is HALT
bp_hit  out  1  one-cycle pulse on breakpoint halt
cmd_err  out  1  one-cycle pulse on rejected command
retired  out  CNT_W  count of cpu_en cycles, saturating
wd_hit  out  1  one-cycle pulse on watchdog halt

Behaviour:
- Reset: clk only, when reset==0 at posedge. State HALT; cpu_en, mem_sel, mem_we, bp_hit, cmd_err, wd_hit = 0; mem_addr, mem_wdata = 0; retired = 0; breakpoint disabled, bp_addr = 0; halted = 1. Reset mid-operation aborts any in-flight write: mem_we is low in the reset cycle.
- States: HALT, RUN, STEP, LOAD. cmd_ready = 1 in HALT and RUN, 0 in STEP and LOAD.
- All outputs are registered. The effect of a command appears the cycle after acceptance.
- HALT:
  - RUN -> RUN; set arm_skip.
  - STEP -> STEP.
  - WRITE -> LOAD; latch addr/data.
  - SETBP: bp_addr=cmd_addr, bp_en=1. CLRBP: bp_en=0. CLRCNT: retired=0. Stay in HALT for all three.
  - HALT and NOP: no effect.
- STEP: cpu_en=1 for exactly one cycle, then HALT. Breakpoints are ignored.
- LOAD: mem_sel=1 and mem_we=1 for exactly one cycle with the latched addr/data, cpu_en=0, then HALT. mem_sel=0 in all other states.
- RUN: cpu_en=1 every cycle, except:
  - Breakpoint: if bp_en and pc==bp_addr and arm_skip==0, then cpu_en=0, bp_hit pulse, go to HALT. arm_skip clears after the first RUN cycle, so resuming from a breakpoint executes that instruction.
  - HALT command accepted: cpu_en=0 from the next cycle, go to HALT.
  - Same-cycle breakpoint and HALT command: go to HALT with bp_hit asserted.
  - WRITE/STEP/SETBP/CLRBP accepted in RUN: ignored, with a cmd_err pulse. RUN, NOP and CLRCNT in RUN are legal; CLRCNT clears retired.
- retired increments on every cycle with cpu_en=1 and saturates at all-ones. CLRCNT in the same cycle wins.
- PC wrap (15->0) is the core's concern. Breakpoints compare the full ADDR_W only.

Optional Feature:
DL_WATCHDOG_EN:
- Defined: a run counter clears on entry to RUN and counts cpu_en cycles in RUN. When it reaches RUN_LIMIT, the controller forces HALT, pulses wd_hit and drops cpu_en. If the breakpoint and watchdog fire in the same cycle, both pulses assert.
- Undefined: no counter; wd_hit is tied 0 and RUN is unbounded.

Test Plan:
- Release reset, then STEP x3 -> exactly 3 single-cycle cpu_en pulses; retired=3; halted returns to 1 after each.
- WRITE addr=5 data=0x96 from HALT -> one cycle with mem_sel=1, mem_we=1, mem_addr=5, mem_wdata=0x96; cpu_en=0 throughout.
- SETBP 4, RUN, with pc driven 0,1,2,3,4 -> cpu_en high 4 cycles; at pc=4 cpu_en=0 and bp_hit pulses; RUN again -> instruction at 4 executes, no re-hit.
- WRITE during RUN -> cmd_err pulse, mem_we stays 0, cpu_en stays 1; then HALT -> cpu_en=0 the next cycle.
- Pull reset low mid-LOAD and mid-RUN -> next cycle halted=1, cpu_en=0, mem_we=0, retired=0, breakpoint cleared.
- DL_WATCHDOG_EN, RUN_LIMIT=10, RUN with no breakpoint -> exactly 10 cpu_en cycles, then wd_hit pulse and HALT.
